// File: rtl/ranger_pkg.sv
// Shared constants and helpers for the HC-SR04 ranger: FSM state codes,
// default timing and counter-width sizing.
package ranger_pkg;

  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_PERIOD_CYC  = 3_000_000;
  localparam int DEF_TIMEOUT_CYC = 1_500_000;
  localparam int DEF_CLKS_PER_CM = 2900;
  localparam int DEF_MAX_CM      = 400;

  localparam int CM_W = 9;

  localparam logic [1:0] ST_TRIG      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by an edge
// detector giving single-cycle rise/fall strobes aligned with `level`.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 driver: free-running trigger period, echo width timing and
// conversion to whole centimetres with a clocks-per-cm prescaler.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CLKS_PER_CM = DEF_CLKS_PER_CM,
  parameter int MAX_CM      = DEF_MAX_CM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [32:0] distance,
  output logic        valid,
  output logic        out_of_range,
  output logic [1:0]  fsm_state
);

  // The trigger phase reuses the wait timer, so it must fit inside it.
  if (TRIG_CYC > TIMEOUT_CYC || CLK_HZ < 1) begin : g_bad_params
    $error("ultrasonic_ranger: invalid timing parameters");
  end

  localparam int PW = cnt_w(PERIOD_CYC);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam int SW = cnt_w(CLKS_PER_CM);

  localparam logic [PW-1:0]   PER_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0]   TRIG_LAST = TW'(TRIG_CYC - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]   SUB_LAST  = SW'(CLKS_PER_CM - 1);
  localparam logic [CM_W-1:0] CM_MAX    = CM_W'(MAX_CM);

  logic [1:0]      state;
  logic [PW-1:0]   per_cnt;
  logic [TW-1:0]   tmr;
  logic [SW-1:0]   sub, sub_n;
  logic [CM_W-1:0] cm, cm_n, dist_q;
  logic            echo_s, echo_rise, echo_fall;
  logic            boundary;

  echo_sync u_echo_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (echo),
    .level (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  always_ff @(posedge clk) begin
    if (rst || per_cnt == PER_LAST) per_cnt <= '0;
    else                            per_cnt <= per_cnt + 1'b1;
  end

  assign boundary = (per_cnt == '0);

  // Every MEASURE cycle counts, including the fall cycle: it stands in for
  // the rise cycle spent leaving WAIT_RISE, so cm = floor(width / CLKS_PER_CM).
  always_comb begin
    sub_n = sub + 1'b1;
    cm_n  = cm;
    if (sub == SUB_LAST) begin
      sub_n = '0;
      if (cm != CM_MAX) cm_n = cm + 1'b1;
    end
  end

  // valid is a one-cycle strobe with no backpressure: distance and
  // out_of_range are stable from that cycle until the next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_TRIG;
      tmr          <= '0;
      sub          <= '0;
      cm           <= '0;
      trig         <= 1'b0;
      dist_q       <= '0;
      valid        <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_TRIG: begin
          if (!trig) begin
            trig <= 1'b1;
            tmr  <= '0;
          end else if (tmr == TRIG_LAST) begin
            trig  <= 1'b0;
            tmr   <= '0;
            state <= ST_WAIT_RISE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (boundary) begin
            dist_q       <= CM_MAX;
            out_of_range <= 1'b1;
            valid        <= 1'b1;
            trig         <= 1'b1;
            tmr          <= '0;
            state        <= ST_TRIG;
          end else if (echo_rise) begin
            sub   <= '0;
            cm    <= '0;
            state <= ST_MEASURE;
          end else if (tmr == TMO_LAST) begin
            dist_q       <= CM_MAX;
            out_of_range <= 1'b1;
            valid        <= 1'b1;
            state        <= ST_HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_MEASURE: begin
          sub <= sub_n;
          cm  <= cm_n;
          if (boundary) begin
            dist_q       <= CM_MAX;
            out_of_range <= 1'b1;
            valid        <= 1'b1;
            trig         <= 1'b1;
            tmr          <= '0;
            state        <= ST_TRIG;
          end else if (echo_fall) begin
            dist_q       <= cm_n;
            out_of_range <= (cm_n == CM_MAX);
            valid        <= 1'b1;
            state        <= ST_HOLD;
          end
        end
        default: begin
          if (boundary) begin
            trig  <= 1'b1;
            tmr   <= '0;
            state <= ST_TRIG;
          end
        end
      endcase
    end
  end

  assign distance  = {24'd0, dist_q};
  assign fsm_state = state;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened timing: results are
// predicted into a queue when echo is driven and checked on each valid.
module tb_ultrasonic_ranger;

  localparam int TRIG_CYC    = 5;
  localparam int PERIOD_CYC  = 3000;
  localparam int TIMEOUT_CYC = 1500;
  localparam int CLKS_PER_CM = 29;
  localparam int MAX_CM      = 40;
  localparam int W           = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        echo = 1'b0;
  logic        trig, valid, out_of_range;
  logic [32:0] distance;
  logic [1:0]  fsm_state;

  ultrasonic_ranger #(
    .CLK_HZ      (500_000),
    .TRIG_CYC    (TRIG_CYC),
    .PERIOD_CYC  (PERIOD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CLKS_PER_CM (CLKS_PER_CM),
    .MAX_CM      (MAX_CM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .echo         (echo),
    .trig         (trig),
    .distance     (distance),
    .valid        (valid),
    .out_of_range (out_of_range),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog observed=%0d cycles expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard: {out_of_range, distance}
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  logic trig_d = 1'b0;
  int trig_rise_cyc = 0, trig_fall_cyc = 0, trig_fall_n = 0;
  int valid_cyc = 0, valid_n = 0;

  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (trig && !trig_d) trig_rise_cyc = cyc;
    if (!trig && trig_d) begin
      trig_fall_cyc = cyc;
      trig_fall_n++;
    end
    trig_d = trig;
    if (valid === 1'b1) begin
      valid_cyc = cyc;
      valid_n++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL sb_unexpected observed=%0d/%0d expected=none", distance, out_of_range);
      end else begin
        exp_v = exp_q.pop_front();
        assert ({out_of_range, distance} === exp_v) else begin
          bad++;
          $error("FAIL sb_result observed=%0d/%0d expected=%0d/%0d",
                 distance, out_of_range, exp_v[32:0], exp_v[33]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_trig_fall(input int budget);
    int start_n = trig_fall_n;
    int k = 0;
    while (trig_fall_n == start_n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("trig_fall_seen", trig_fall_n - start_n, 1);
    tick(1);
  endtask

  task automatic wait_valid(input int start_n, input int budget);
    int k = 0;
    while (valid_n == start_n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("valid_seen", valid_n - start_n, 1);
  endtask

  task automatic measure(input string tag, input int width,
                         input logic [8:0] exp_cm, input logic exp_oor);
    int fall_cyc;
    int vn;
    wait_trig_fall(PERIOD_CYC + 100);
    tick(10);
    echo = 1'b1;
    tick(width);
    echo = 1'b0;
    fall_cyc = cyc;
    exp_q.push_back({exp_oor, 24'd0, exp_cm});
    vn = valid_n;
    wait_valid(vn, 50);
    chk({tag, "_latency"}, valid_cyc - fall_cyc, 3);
    @(negedge clk);
    chk({tag, "_valid_width"}, valid, 0);
  endtask

  // directed sequence
  initial begin
    int rel;
    int first_rise;
    int vn;

    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_distance", distance, 0);
    chk("rst_valid", valid, 0);
    chk("rst_oor", out_of_range, 0);
    chk("rst_state", fsm_state, 0);

    // 1: no echo -> timeout result
    rst = 1'b0;
    rel = cyc;
    exp_q.push_back({1'b1, 33'(MAX_CM)});
    wait_trig_fall(50);
    chk("t1_trig_start", trig_rise_cyc, rel + 1);
    chk("t1_trig_width", trig_fall_cyc - trig_rise_cyc, TRIG_CYC);
    first_rise = trig_rise_cyc;
    vn = valid_n;
    wait_valid(vn, TIMEOUT_CYC + 50);
    chk("t1_timeout_latency", valid_cyc - trig_fall_cyc, TIMEOUT_CYC);

    // 2..4: normal, floor boundary, saturation and recovery
    measure("t2", 290, 9'd10, 1'b0);
    chk("t2_period", trig_rise_cyc - first_rise, PERIOD_CYC);
    measure("t3a", 202, 9'd6, 1'b0);
    measure("t3b", 203, 9'd7, 1'b0);
    measure("t4a", 1200, 9'(MAX_CM), 1'b1);
    measure("t4b", 58, 9'd2, 1'b0);
    chk("t4b_oor_cleared", out_of_range, 0);

    // period boundary while still measuring: timeout and immediate retrigger
    wait_trig_fall(PERIOD_CYC + 100);
    tick(10);
    echo = 1'b1;
    exp_q.push_back({1'b1, 33'(MAX_CM)});
    vn = valid_n;
    wait_valid(vn, PERIOD_CYC + 100);
    chk("t7_retrig_same_edge", trig_rise_cyc, valid_cyc);
    exp_q.push_back({1'b1, 33'(MAX_CM)});
    vn = valid_n;
    wait_valid(vn, TIMEOUT_CYC + 100);
    chk("t7_held_high_timeout", valid_cyc - trig_fall_cyc, TIMEOUT_CYC);

    // 5: echo stuck high from reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rel = cyc;
    exp_q.push_back({1'b1, 33'(MAX_CM)});
    wait_trig_fall(50);
    chk("t5_trig_start", trig_rise_cyc, rel + 1);
    first_rise = trig_rise_cyc;
    vn = valid_n;
    wait_valid(vn, TIMEOUT_CYC + 50);
    chk("t5_timeout_latency", valid_cyc - trig_fall_cyc, TIMEOUT_CYC);
    exp_q.push_back({1'b1, 33'(MAX_CM)});
    wait_trig_fall(PERIOD_CYC + 100);
    chk("t5_period", trig_rise_cyc - first_rise, PERIOD_CYC);
    vn = valid_n;
    wait_valid(vn, TIMEOUT_CYC + 50);
    echo = 1'b0;

    // 6: reset in the middle of MEASURE
    wait_trig_fall(PERIOD_CYC + 100);
    tick(10);
    echo = 1'b1;
    tick(100);
    chk("t6_pre_state", fsm_state, 2);
    rst = 1'b1;
    tick(1);
    chk("t6_trig", trig, 0);
    chk("t6_distance", distance, 0);
    chk("t6_valid", valid, 0);
    chk("t6_oor", out_of_range, 0);
    chk("t6_state", fsm_state, 0);
    rel = cyc;
    rst = 1'b0;
    echo = 1'b0;
    measure("t6_after", 58, 9'd2, 1'b0);
    chk("t6_trig_start", trig_rise_cyc, rel + 1);

    chk("sb_empty", exp_q.size(), 0);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
